sub_bytes_pipe: RTL and testbench

- Parametrised, pipelined AES byte-substitution unit: LANES independent 8-bit S-box lanes in parallel.
- Runtime-selectable forward (SubBytes) or inverse (InvSubBytes) mode, per beat.
- Per-lane bypass mask, so the same block serves the round datapath (16 lanes) and key expansion SubWord (4 lanes).
- Sits between AddRoundKey and ShiftRows; uses valid/ready flow control with full backpressure.

---
 rtl/sub_bytes_pipe.sv | 116 +++++++++++
 tb/tb_sub_bytes_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_pipe.sv
// Pipelined AES SubBytes / InvSubBytes over LANES byte lanes with per-lane bypass.
// The substitution is computed before slot 0; the STAGES slots then carry results under valid/ready.
module sub_bytes_pipe #(
   parameter int LANES  = 16,
   parameter int STAGES = 2,
   parameter int INV_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_data,
   input  logic                 in_inv,
   input  logic [LANES-1:0]     in_mask,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*LANES-1:0]   out_data
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 by repeated squaring; maps 0 to 0 without a special case
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] s;
      logic [7:0] r;
      s = x;
      r = 8'h01;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [15:0] w;
      w = {x, x} << n;
      return w[15:8];
   endfunction

   function automatic logic [7:0] fwd_affine(input logic [7:0] x);
      return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] x);
      return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
   endfunction

   // One inverter shared by both directions; affine maps on either side select the mode
   function automatic logic [7:0] lane_sub(input logic [7:0] x, input logic inv);
      logic [7:0] g;
      g = gf_inv(inv ? inv_affine(x) : x);
      return inv ? g : fwd_affine(g);
   endfunction

   logic                 inv_eff;
   logic [8*LANES-1:0]   sub_data;
   logic [STAGES-1:0]    vld_p;
   logic [STAGES-1:0]    load;
   logic [8*LANES-1:0]   data_p [STAGES];

   assign inv_eff = (INV_EN != 0) ? in_inv : 1'b0;

   always_comb begin
      sub_data = in_data;
      for (int i = 0; i < LANES; i++) begin
         if (in_mask[i]) sub_data[8*i +: 8] = lane_sub(in_data[8*i +: 8], inv_eff);
      end
   end

   // A slot may load when it or any slot downstream is empty, or the output drains
   always_comb begin
      logic full;
      load = '0;
      for (int k = 0; k < STAGES; k++) begin
         full = 1'b1;
         for (int j = k; j < STAGES; j++) full = full & vld_p[j];
         load[k] = !full || out_ready;
      end
   end

   // ---- stage boundary: substituted data into slot 0, then slot-to-slot shift
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         if (load[0]) vld_p[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            if (load[k]) vld_p[k] <= vld_p[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load[0]) data_p[0] <= sub_data;
      for (int k = 1; k < STAGES; k++) begin
         if (load[k]) data_p[k] <= data_p[k-1];
      end
   end

   // ---- output: data forced to zero while idle so it reads 0 after reset
   assign in_ready  = load[0];
   assign out_valid = vld_p[STAGES-1];
   assign out_data  = vld_p[STAGES-1] ? data_p[STAGES-1] : '0;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Scoreboard bench for sub_bytes_pipe: driver pushes expected beats, a negedge monitor pops and compares.
// Golden S-boxes are built by brute-force GF inverse search plus a bitwise affine map.
module tb_sub_bytes_pipe;
   localparam int LANES  = 16;
   localparam int STAGES = 2;
   localparam int W      = 8*LANES;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic           in_inv;
   logic [LANES-1:0] in_mask;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;

   logic           ready_fixed;
   logic           rnd_ready;
   logic           rnd_bit;
   assign out_ready = rnd_ready ? rnd_bit : ready_fixed;

   sub_bytes_pipe #(.LANES(LANES), .STAGES(STAGES), .INV_EN(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_inv(in_inv), .in_mask(in_mask),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t       sb_q [$];
   logic [7:0] sbox [256];
   logic [7:0] isbox [256];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         occ = 0;
   bit         held_v = 0;
   logic [W-1:0] held_d;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
      for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011b << (k - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] ref_aff(input logic [7:0] v);
      logic [7:0] c;
      logic [7:0] b;
      c = 8'h63;
      for (int i = 0; i < 8; i++)
         b[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      return b;
   endfunction

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic inv, input logic [LANES-1:0] m);
      logic [W-1:0] r;
      logic [7:0]   x;
      for (int i = 0; i < LANES; i++) begin
         x = d[8*i +: 8];
         r[8*i +: 8] = m[i] ? (inv ? isbox[x] : sbox[x]) : x;
      end
      return r;
   endfunction

   task automatic send(input logic [W-1:0] d, input logic inv, input logic [LANES-1:0] m,
                       input logic [W-1:0] e, input bit lat);
      int   n;
      exp_t x;
      n = 0;
      in_data = d; in_inv = inv; in_mask = m; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL send_timeout actual=in_ready_low required=accept");
      end else begin
         x.d = e; x.acc = cyc; x.lat = lat;
         sb_q.push_back(x);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [W-1:0] d, input logic inv, input logic [LANES-1:0] m, input bit lat);
      send(d, inv, m, model(d, inv, m), lat);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d required=0", sb_q.size());
      end
   endtask

   // Monitor: sampled mid-cycle, so it sees what the next rising edge will do
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb_q.delete();
         occ = 0;
         held_v = 0;
      end else begin
         check("in_ready", W'(in_ready), W'((occ < STAGES) || out_ready));
         if (held_v) begin
            check("stall_valid", W'(out_valid), W'(1));
            check("stall_data", out_data, held_d);
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_beat actual=%h required=no_beat", out_data);
            end else begin
               e = sb_q.pop_front();
               check("out_data", out_data, e.d);
               if (e.lat) check("latency", W'(cyc - e.acc), W'(STAGES));
            end
         end
         occ = occ + ((in_valid && in_ready) ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
         held_v = out_valid && !out_ready;
         held_d = out_data;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]     d;
      logic [7:0]       iv;
      logic [W-1:0]     fips_in;
      logic [W-1:0]     fips_out;

      for (int x = 0; x < 256; x++) begin
         iv = 8'h00;
         for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
         sbox[x] = ref_aff(iv);
      end
      for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; in_mask = '1;
      ready_fixed = 1'b1; rnd_ready = 1'b0; rnd_bit = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", W'(out_valid), W'(0));
      check("reset_out_data", out_data, '0);
      check("reset_in_ready", W'(in_ready), W'(1));
      rst = 1'b0;

      send({{13{8'h00}}, 8'hFF, 8'h53, 8'h00}, 1'b0, '1,
           {{13{8'h63}}, 8'h16, 8'hED, 8'h63}, 1'b1);

      fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      fips_out = 128'hd42711aee0bf98f1b8b45de51e415230;
      send(fips_in,  1'b0, '1, fips_out, 1'b1);
      send(fips_out, 1'b1, '1, fips_in,  1'b1);
      send(fips_in,  1'b0, '1, fips_out, 1'b1);
      send(fips_out, 1'b1, '1, fips_in,  1'b1);

      send({96'h0, 32'h09cf4f3c}, 1'b0, 16'h000F, {96'h0, 32'h018a84eb}, 1'b1);
      send({96'h0, 32'h09cf4f3c}, 1'b0, 16'h0005, {96'h0, 32'h098a4feb}, 1'b1);
      send(fips_in, 1'b1, 16'h0000, fips_in, 1'b1);
      wait_empty();

      // Backpressure: counting bytes under random out_ready
      rnd_ready = 1'b1;
      fork
         begin
            for (int b = 0; b < 8; b++) begin
               for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'(b*LANES + i);
               send_m(d, 1'b0, '1, 1'b0);
            end
            wait_empty();
         end
         begin
            repeat (200) begin
               @(posedge clk); #1;
               rnd_bit = 1'($urandom_range(0, 1));
            end
         end
      join_any
      disable fork;
      rnd_ready = 1'b0;

      // Reset with two beats in flight and the output stalled
      ready_fixed = 1'b0;
      send_m(fips_in, 1'b0, '1, 1'b0);
      send_m(fips_out, 1'b1, '1, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_out_valid", W'(out_valid), W'(0));
      check("midrst_out_data", out_data, '0);
      check("midrst_in_ready", W'(in_ready), W'(1));
      rst = 1'b0;
      ready_fixed = 1'b1;
      idle(8);
      check("post_rst_idle", W'(out_valid), W'(0));

      for (int inv = 0; inv < 2; inv++) begin
         for (int b = 0; b < 256 / LANES; b++) begin
            for (int i = 0; i < LANES; i++) d[8*i +: 8] = 8'(b*LANES + i);
            send_m(d, 1'(inv), '1, 1'b1);
         end
      end
      wait_empty();

      rnd_ready = 1'b1;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               d = {$urandom, $urandom, $urandom, $urandom};
               send_m(d, 1'($urandom_range(0, 1)), LANES'($urandom), 1'b0);
               idle($urandom_range(0, 2));
            end
            wait_empty();
         end
         begin
            repeat (1000) begin
               @(posedge clk); #1;
               rnd_bit = 1'($urandom_range(0, 1));
            end
         end
      join_any
      disable fork;
      rnd_ready = 1'b0;
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
